// File: rtl/seg_scan_display_pkg.sv
// Shared 7-segment codes and value types for the scanned address/data display.
// Segment codes are active-low {dp,g,f,e,d,c,b,a} with the dp bit held off.
package seg_scan_display_pkg;

    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_A     = 8'h88;
    localparam logic [7:0] SEG_B     = 8'h83;
    localparam logic [7:0] SEG_C     = 8'hC6;
    localparam logic [7:0] SEG_D     = 8'hA1;
    localparam logic [7:0] SEG_E     = 8'h86;
    localparam logic [7:0] SEG_F     = 8'h8E;
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [5:0] DIG_OFF   = 6'h3F;

    typedef struct packed {
        logic [4:0] addr;
        logic [3:0] data;
    } disp_val_t;

    typedef struct packed {
        logic [1:0] tens;
        logic [3:0] ones;
    } dec_split_t;

    // Address range is only 0-31, so a compare ladder beats a real divider.
    function automatic dec_split_t dec_split(input logic [4:0] a);
        dec_split_t r;
        logic [4:0] off;
        if (a >= 5'd30) begin
            r.tens = 2'd3;
            off    = 5'd30;
        end else if (a >= 5'd20) begin
            r.tens = 2'd2;
            off    = 5'd20;
        end else if (a >= 5'd10) begin
            r.tens = 2'd1;
            off    = 5'd10;
        end else begin
            r.tens = 2'd0;
            off    = 5'd0;
        end
        r.ones = 4'(a - off);
        return r;
    endfunction

endpackage

// File: rtl/seg7_hex_dec.sv
// Combinational 4-bit hex to active-low 7-segment decoder, output {g,f,e,d,c,b,a}.
module seg7_hex_dec
    import seg_scan_display_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg_n
);

    always_comb begin
        seg_n = SEG_BLANK[6:0];
        case (hex)
            4'h0:    seg_n = SEG_0[6:0];
            4'h1:    seg_n = SEG_1[6:0];
            4'h2:    seg_n = SEG_2[6:0];
            4'h3:    seg_n = SEG_3[6:0];
            4'h4:    seg_n = SEG_4[6:0];
            4'h5:    seg_n = SEG_5[6:0];
            4'h6:    seg_n = SEG_6[6:0];
            4'h7:    seg_n = SEG_7[6:0];
            4'h8:    seg_n = SEG_8[6:0];
            4'h9:    seg_n = SEG_9[6:0];
            4'hA:    seg_n = SEG_A[6:0];
            4'hB:    seg_n = SEG_B[6:0];
            4'hC:    seg_n = SEG_C[6:0];
            4'hD:    seg_n = SEG_D[6:0];
            4'hE:    seg_n = SEG_E[6:0];
            default: seg_n = SEG_F[6:0];
        endcase
    end

endmodule

// File: rtl/seg_scan_display.sv
// Six-digit scanned display of ROM address (decimal) and data (hex), frame-synchronised
// so a new value only appears at a frame start; digit-0 DP flashes after each update.
module seg_scan_display
    import seg_scan_display_pkg::*;
#(
    parameter int unsigned SCAN_CNT_MAX  = 49_999,
    parameter int unsigned FLASH_CNT_MAX = 12_499_999
) (
    input  logic       sclk,
    input  logic       nrst,
    input  logic [4:0] addr,
    input  logic [3:0] data,
    input  logic       upd,
    output logic [5:0] sel_n,
    output logic [7:0] seg_n
);

    localparam int SCAN_W  = (SCAN_CNT_MAX  > 0) ? $clog2(SCAN_CNT_MAX + 1)  : 1;
    localparam int FLASH_W = (FLASH_CNT_MAX > 0) ? $clog2(FLASH_CNT_MAX + 1) : 1;

    logic [SCAN_W-1:0]  scan_cnt;
    logic [2:0]         dig_idx;
    disp_val_t          pend;
    disp_val_t          shadow;
    logic               pend_vld;
    logic [FLASH_W-1:0] flash_cnt;
    logic               flash_act;

    logic       tick;
    logic       frame_end;
    logic       load;
    dec_split_t dec;
    logic [3:0] hex_in;
    logic [6:0] hex_seg_n;
    logic       lit;
    logic       dp_n;
    logic [5:0] sel_nxt;
    logic [7:0] seg_nxt;

    assign tick      = (scan_cnt == SCAN_W'(SCAN_CNT_MAX));
    assign frame_end = tick && (dig_idx == 3'd5);
    assign load      = frame_end && pend_vld;
    assign dec       = dec_split(shadow.addr);

    seg7_hex_dec u_hex_dec (
        .hex   (hex_in),
        .seg_n (hex_seg_n)
    );

    always_comb begin
        hex_in = shadow.data;
        lit    = 1'b0;
        case (dig_idx)
            3'd5: begin
                hex_in = {2'b00, dec.tens};
                lit    = (shadow.addr >= 5'd10);
            end
            3'd4: begin
                hex_in = dec.ones;
                lit    = 1'b1;
            end
            3'd0: begin
                hex_in = shadow.data;
                lit    = 1'b1;
            end
            default: lit = 1'b0;
        endcase
        dp_n    = !((dig_idx == 3'd0) && flash_act);
        sel_nxt = lit ? ~(6'd1 << dig_idx) : DIG_OFF;
        seg_nxt = lit ? {dp_n, hex_seg_n} : SEG_BLANK;
    end

    always_ff @(posedge sclk or negedge nrst) begin
        if (!nrst) begin
            scan_cnt  <= '0;
            dig_idx   <= 3'd0;
            pend      <= '0;
            pend_vld  <= 1'b0;
            shadow    <= '0;
            flash_cnt <= '0;
            flash_act <= 1'b0;
            sel_n     <= DIG_OFF;
            seg_n     <= SEG_BLANK;
        end else begin
            scan_cnt <= tick ? '0 : scan_cnt + 1'b1;
            if (tick) begin
                dig_idx <= (dig_idx == 3'd5) ? 3'd0 : dig_idx + 3'd1;
            end

            // A same-cycle upd lands in pend while the older pend moves to shadow.
            if (upd) begin
                pend     <= '{addr: addr, data: data};
                pend_vld <= 1'b1;
            end else if (load) begin
                pend_vld <= 1'b0;
            end
            if (load) begin
                shadow <= pend;
            end

            if (load) begin
                flash_act <= 1'b1;
                flash_cnt <= FLASH_W'(FLASH_CNT_MAX);
            end else if (flash_act) begin
                if (flash_cnt == '0) begin
                    flash_act <= 1'b0;
                end else begin
                    flash_cnt <= flash_cnt - 1'b1;
                end
            end

            sel_n <= sel_nxt;
            seg_n <= seg_nxt;
        end
    end

endmodule
